// File: rtl/debug_cmd_sequencer_pkg.sv
// Shared opcodes, reply constants and FSM state type for the UART debug command sequencer.
package debug_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [7:0] OP_SET_COUNT  = 8'h82;
  localparam logic [7:0] OP_SET_ADDR   = 8'h83;
  localparam logic [7:0] OP_READ_DATA  = 8'h84;
  localparam logic [7:0] OP_WRITE_DATA = 8'h85;
  localparam logic [7:0] OP_ALIVE      = 8'h86;
  localparam logic [7:0] OP_CORE_RST   = 8'h87;
  localparam logic [7:0] OP_CORE_NORM  = 8'h88;

  localparam logic [15:0] ALIVE_RESP = 16'h00AE;

  typedef enum logic [2:0] {
    S_IDLE,
    S_GET_COUNT,
    S_GET_ADDR,
    S_GET_WDATA,
    S_BUS_WRITE,
    S_BUS_READ,
    S_SEND_RDATA,
    S_SEND_ALIVE
  } dbg_state_t;

endpackage

// File: rtl/debug_cmd_sequencer_if.sv
// Byte stream (UART RX/TX) and single-word bus-master signals of the debug command sequencer.
interface debug_cmd_sequencer_if;
  import debug_pkg::*;

  logic            rx_valid;
  logic [7:0]      rx_data;
  logic            tx_valid;
  logic [7:0]      tx_data;
  logic            tx_ready;
  logic [XLEN-1:0] bus_addr;
  logic [XLEN-1:0] bus_wdata;
  logic            bus_wen;
  logic            bus_ren;
  logic            bus_busy;
  logic [XLEN-1:0] bus_rdata;

  // master: the sequencer; slave: UART engines plus interconnect around it
  modport master (
    input  rx_valid, rx_data, tx_ready, bus_busy, bus_rdata,
    output tx_valid, tx_data, bus_addr, bus_wdata, bus_wen, bus_ren
  );

  modport slave (
    output rx_valid, rx_data, tx_ready, bus_busy, bus_rdata,
    input  tx_valid, tx_data, bus_addr, bus_wdata, bus_wen, bus_ren
  );

endinterface

// File: rtl/debug_cmd_sequencer.sv
// Parses host debug bytes into single-word bus transactions, emits reply bytes
// and owns the debugger-controlled core reset.
module debug_cmd_sequencer
  import debug_pkg::*;
(
  input  logic                   clk,
  input  logic                   n_rst,
  debug_cmd_sequencer_if.master  dbg,
  output logic                   core_rst_o
);

  dbg_state_t      state_q;
  logic [1:0]      idx_q;
  logic [8:0]      words_q;
  logic [7:0]      count_q;
  logic [XLEN-1:0] addr_q;
  logic [XLEN-1:0] shin_q;
  logic [XLEN-1:0] shout_q;

  logic            tx_valid_q;
  logic [7:0]      tx_data_q;
  logic            bus_wen_q;
  logic            bus_ren_q;
  logic [XLEN-1:0] bus_addr_q;
  logic [XLEN-1:0] bus_wdata_q;
  logic            core_rst_q;

  logic [XLEN-1:0] addr_next_d;
  logic [XLEN-1:0] shin_d;
  logic            tx_fire_d;
  logic            last_word_d;

  always_comb begin
    addr_next_d = addr_q + XLEN'(4);
    shin_d      = {shin_q[XLEN-9:0], dbg.rx_data};
    tx_fire_d   = tx_valid_q && dbg.tx_ready;
    last_word_d = (words_q == 9'd1);
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      words_q     <= '0;
      count_q     <= 8'd1;
      addr_q      <= '0;
      shin_q      <= '0;
      shout_q     <= '0;
      tx_valid_q  <= 1'b0;
      tx_data_q   <= '0;
      bus_wen_q   <= 1'b0;
      bus_ren_q   <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      core_rst_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (dbg.rx_valid) begin
            case (dbg.rx_data)
              OP_SET_COUNT: state_q <= S_GET_COUNT;
              OP_SET_ADDR: begin
                idx_q   <= '0;
                state_q <= S_GET_ADDR;
              end
              OP_WRITE_DATA: begin
                if (count_q != '0) begin
                  words_q <= {1'b0, count_q};
                  idx_q   <= '0;
                  state_q <= S_GET_WDATA;
                end
              end
              OP_READ_DATA: begin
                if (count_q != '0) begin
                  words_q    <= {1'b0, count_q};
                  bus_ren_q  <= 1'b1;
                  bus_addr_q <= addr_q;
                  state_q    <= S_BUS_READ;
                end
              end
              OP_ALIVE: begin
                // ALIVE reuses the read-reply shifter: first byte goes out now, second waits in [23:16]
                tx_valid_q <= 1'b1;
                tx_data_q  <= ALIVE_RESP[15:8];
                shout_q    <= {ALIVE_RESP, 16'h0000};
                idx_q      <= '0;
                state_q    <= S_SEND_ALIVE;
              end
              OP_CORE_RST:  core_rst_q <= 1'b1;
              OP_CORE_NORM: core_rst_q <= 1'b0;
              default: ;
            endcase
          end
        end

        S_GET_COUNT: begin
          if (dbg.rx_valid) begin
            count_q <= dbg.rx_data;
            state_q <= S_IDLE;
          end
        end

        S_GET_ADDR: begin
          if (dbg.rx_valid) begin
            shin_q <= shin_d;
            idx_q  <= idx_q + 2'd1;
            if (idx_q == 2'd3) begin
              addr_q  <= shin_d;
              state_q <= S_IDLE;
            end
          end
        end

        S_GET_WDATA: begin
          if (dbg.rx_valid) begin
            shin_q <= shin_d;
            idx_q  <= idx_q + 2'd1;
            if (idx_q == 2'd3) begin
              bus_wdata_q <= shin_d;
              bus_addr_q  <= addr_q;
              bus_wen_q   <= 1'b1;
              state_q     <= S_BUS_WRITE;
            end
          end
        end

        S_BUS_WRITE: begin
          if (!dbg.bus_busy) begin
            bus_wen_q  <= 1'b0;
            addr_q     <= addr_next_d;
            bus_addr_q <= addr_next_d;
            words_q    <= words_q - 9'd1;
            idx_q      <= '0;
            state_q    <= last_word_d ? S_IDLE : S_GET_WDATA;
          end
        end

        S_BUS_READ: begin
          if (!dbg.bus_busy) begin
            bus_ren_q  <= 1'b0;
            shout_q    <= dbg.bus_rdata;
            tx_valid_q <= 1'b1;
            tx_data_q  <= dbg.bus_rdata[31:24];
            idx_q      <= '0;
            state_q    <= S_SEND_RDATA;
          end
        end

        S_SEND_RDATA: begin
          if (tx_fire_d) begin
            if (idx_q == 2'd3) begin
              // next word's request overlaps the final handshake so no idle cycle appears
              tx_valid_q <= 1'b0;
              addr_q     <= addr_next_d;
              bus_addr_q <= addr_next_d;
              words_q    <= words_q - 9'd1;
              if (last_word_d) begin
                state_q <= S_IDLE;
              end else begin
                bus_ren_q <= 1'b1;
                state_q   <= S_BUS_READ;
              end
            end else begin
              tx_data_q <= shout_q[23:16];
              shout_q   <= {shout_q[XLEN-9:0], 8'h00};
              idx_q     <= idx_q + 2'd1;
            end
          end
        end

        S_SEND_ALIVE: begin
          if (tx_fire_d) begin
            if (idx_q == 2'd1) begin
              tx_valid_q <= 1'b0;
              state_q    <= S_IDLE;
            end else begin
              tx_data_q <= shout_q[23:16];
              shout_q   <= {shout_q[XLEN-9:0], 8'h00};
              idx_q     <= idx_q + 2'd1;
            end
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign dbg.tx_valid  = tx_valid_q;
  assign dbg.tx_data   = tx_data_q;
  assign dbg.bus_wen   = bus_wen_q;
  assign dbg.bus_ren   = bus_ren_q;
  assign dbg.bus_addr  = bus_addr_q;
  assign dbg.bus_wdata = bus_wdata_q;
  assign core_rst_o    = core_rst_q;

endmodule

// File: tb/tb_debug_cmd_sequencer.sv
// Directed bench for debug_cmd_sequencer: host byte driver, bus slave with stalls, TX sink.
module tb_debug_cmd_sequencer;
  import debug_pkg::*;

  logic clk = 1'b0;
  logic n_rst = 1'b0;
  logic core_rst;

  debug_cmd_sequencer_if dif ();

  debug_cmd_sequencer dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .dbg        (dif.master),
    .core_rst_o (core_rst)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  logic [31:0] wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  logic [31:0] rd_addr_q[$];
  logic [31:0] rd_resp_q[$];
  logic [7:0]  tx_q[$];

  int unsigned stall_cfg  = 0;
  int unsigned stall_left = 0;
  bit          rand_ready = 1'b0;
  bit          req_active = 1'b0;
  int unsigned both_high  = 0;

  // Slave and sink decide at negedge what the DUT will see on the next posedge.
  always @(negedge clk) begin
    if (dif.bus_wen && dif.bus_ren) both_high++;
    if (dif.bus_wen || dif.bus_ren) begin
      if (!req_active) begin
        req_active = 1'b1;
        stall_left = stall_cfg;
      end
      if (stall_left > 0) begin
        dif.bus_busy = 1'b1;
        stall_left--;
      end else begin
        dif.bus_busy = 1'b0;
        req_active   = 1'b0;
        if (dif.bus_wen) begin
          wr_addr_q.push_back(dif.bus_addr);
          wr_data_q.push_back(dif.bus_wdata);
        end else begin
          rd_addr_q.push_back(dif.bus_addr);
          dif.bus_rdata = (rd_resp_q.size() > 0) ? rd_resp_q.pop_front() : 32'h0;
        end
      end
    end else begin
      dif.bus_busy = 1'b0;
      req_active   = 1'b0;
    end
    dif.tx_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    if (dif.tx_valid && dif.tx_ready) tx_q.push_back(dif.tx_data);
  end

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    dif.rx_valid = 1'b1;
    dif.rx_data  = b;
    @(negedge clk);
    dif.rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    send(w[31:24]);
    send(w[23:16]);
    send(w[15:8]);
    send(w[7:0]);
  endtask

  task automatic set_addr(input logic [31:0] a);
    send(OP_SET_ADDR);
    send_word(a);
  endtask

  task automatic wait_quiet();
    int quiet = 0;
    for (int i = 0; i < 400 && quiet < 4; i++) begin
      @(negedge clk);
      #1;
      if (!dif.bus_wen && !dif.bus_ren && !dif.tx_valid) quiet++;
      else quiet = 0;
    end
    if (quiet < 4) check_eq("quiet_timeout", 32'd0, 32'd1);
  endtask

  task automatic clear_logs();
    wr_addr_q.delete();
    wr_data_q.delete();
    rd_addr_q.delete();
    tx_q.delete();
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [63:0] exp_rd;
    logic [31:0] rx_word;

    dif.rx_valid = 1'b0;
    dif.rx_data  = 8'h00;
    n_rst        = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check_eq("rst_tx_valid",  {31'b0, dif.tx_valid}, 32'd0);
    check_eq("rst_tx_data",   {24'b0, dif.tx_data},  32'd0);
    check_eq("rst_bus_wen",   {31'b0, dif.bus_wen},  32'd0);
    check_eq("rst_bus_ren",   {31'b0, dif.bus_ren},  32'd0);
    check_eq("rst_bus_addr",  dif.bus_addr,          32'd0);
    check_eq("rst_bus_wdata", dif.bus_wdata,         32'd0);
    check_eq("rst_core_rst",  {31'b0, core_rst},     32'd0);
    @(negedge clk);
    n_rst = 1'b1;

    // ALIVE
    send(OP_ALIVE);
    wait_quiet();
    check_eq("alive_len",   tx_q.size(), 32'd2);
    check_eq("alive_b0",    {24'b0, tx_q[0]}, 32'h00);
    check_eq("alive_b1",    {24'b0, tx_q[1]}, 32'hAE);
    check_eq("alive_nobus", wr_addr_q.size() + rd_addr_q.size(), 32'd0);
    clear_logs();

    // single write
    set_addr(32'h0000_8000);
    send(OP_SET_COUNT); send(8'h01);
    send(OP_WRITE_DATA);
    send_word(32'hDEAD_BEEF);
    wait_quiet();
    check_eq("wr1_len",      wr_addr_q.size(), 32'd1);
    check_eq("wr1_addr",     wr_addr_q[0], 32'h0000_8000);
    check_eq("wr1_data",     wr_data_q[0], 32'hDEAD_BEEF);
    check_eq("wr1_addr_inc", dif.bus_addr, 32'h0000_8004);
    check_eq("wr1_no_tx",    tx_q.size(), 32'd0);
    clear_logs();

    // two reads with slave stalls and random tx_ready
    set_addr(32'h0000_8000);
    send(OP_SET_COUNT); send(8'h02);
    rd_resp_q.push_back(32'h1122_3344);
    rd_resp_q.push_back(32'h5566_7788);
    stall_cfg  = 3;
    rand_ready = 1'b1;
    send(OP_READ_DATA);
    wait_quiet();
    stall_cfg  = 0;
    rand_ready = 1'b0;
    check_eq("rd2_len",   rd_addr_q.size(), 32'd2);
    check_eq("rd2_addr0", rd_addr_q[0], 32'h0000_8000);
    check_eq("rd2_addr1", rd_addr_q[1], 32'h0000_8004);
    check_eq("rd2_txlen", tx_q.size(), 32'd8);
    exp_rd = 64'h1122_3344_5566_7788;
    for (int i = 0; i < 8; i++)
      check_eq($sformatf("rd2_byte%0d", i), {24'b0, tx_q[i]}, {24'b0, exp_rd[63-8*i -: 8]});
    check_eq("rd2_addr_inc", dif.bus_addr, 32'h0000_8008);
    clear_logs();

    // count zero: no bus, no reply; ALIVE still answers
    send(OP_SET_COUNT); send(8'h00);
    send(OP_WRITE_DATA);
    send(OP_READ_DATA);
    wait_quiet();
    check_eq("cnt0_nobus", wr_addr_q.size() + rd_addr_q.size(), 32'd0);
    check_eq("cnt0_notx",  tx_q.size(), 32'd0);
    send(OP_ALIVE);
    wait_quiet();
    check_eq("cnt0_alive_len", tx_q.size(), 32'd2);
    check_eq("cnt0_alive_b1",  {24'b0, tx_q[1]}, 32'hAE);
    clear_logs();

    // core reset held while bus still works; stray bytes ignored
    send(OP_CORE_RST);
    #1;
    check_eq("core_rst_set", {31'b0, core_rst}, 32'd1);
    send(OP_SET_COUNT); send(8'h01);
    set_addr(32'h0000_9000);
    send(OP_WRITE_DATA);
    send_word(32'h1234_5678);
    wait_quiet();
    check_eq("crst_wr_len",  wr_addr_q.size(), 32'd1);
    check_eq("crst_wr_addr", wr_addr_q[0], 32'h0000_9000);
    check_eq("crst_wr_data", wr_data_q[0], 32'h1234_5678);
    check_eq("crst_held",    {31'b0, core_rst}, 32'd1);
    send(OP_CORE_NORM);
    #1;
    check_eq("core_rst_clr", {31'b0, core_rst}, 32'd0);
    send(8'h05);
    send(8'hFF);
    wait_quiet();
    check_eq("stray_nobus", wr_addr_q.size() + rd_addr_q.size(), 32'd1);
    check_eq("stray_notx",  tx_q.size(), 32'd0);
    send(OP_ALIVE);
    wait_quiet();
    check_eq("stray_alive_len", tx_q.size(), 32'd2);
    clear_logs();

    // address wrap across 2^32
    set_addr(32'hFFFF_FFFC);
    send(OP_SET_COUNT); send(8'h02);
    send(OP_WRITE_DATA);
    send_word(32'hA5A5_A5A5);
    wait_quiet();
    send_word(32'h5A5A_5A5A);
    wait_quiet();
    check_eq("wrap_len",   wr_addr_q.size(), 32'd2);
    check_eq("wrap_addr0", wr_addr_q[0], 32'hFFFF_FFFC);
    check_eq("wrap_addr1", wr_addr_q[1], 32'h0000_0000);
    check_eq("wrap_data0", wr_data_q[0], 32'hA5A5_A5A5);
    check_eq("wrap_data1", wr_data_q[1], 32'h5A5A_5A5A);
    check_eq("wrap_final", dif.bus_addr, 32'h0000_0004);

    // async reset in the middle of SET_ADDR
    send(OP_CORE_RST);
    send(OP_SET_ADDR);
    send(8'h12);
    send(8'h34);
    @(negedge clk);
    n_rst = 1'b0;
    #1;
    check_eq("mid_rst_core",  {31'b0, core_rst},     32'd0);
    check_eq("mid_rst_addr",  dif.bus_addr,          32'd0);
    check_eq("mid_rst_wdata", dif.bus_wdata,         32'd0);
    check_eq("mid_rst_txd",   {24'b0, dif.tx_data},  32'd0);
    check_eq("mid_rst_req",   {30'b0, dif.bus_wen, dif.bus_ren}, 32'd0);
    @(negedge clk);
    n_rst = 1'b1;
    clear_logs();

    // after reset: count=1, addr=0, partial address bytes gone
    rd_resp_q.push_back(32'hCAFE_F00D);
    send(OP_READ_DATA);
    wait_quiet();
    check_eq("post_rst_rd_len",  rd_addr_q.size(), 32'd1);
    check_eq("post_rst_rd_addr", rd_addr_q[0], 32'h0000_0000);
    check_eq("post_rst_txlen",   tx_q.size(), 32'd4);
    rx_word = {tx_q[0], tx_q[1], tx_q[2], tx_q[3]};
    check_eq("post_rst_rdata",   rx_word, 32'hCAFE_F00D);

    check_eq("wen_ren_exclusive", both_high, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/debug_cmd_sequencer.md
# debug_cmd_sequencer

Command sequencer behind the UART debug port of `top_level_bASIC`. It parses the host byte stream (SET_COUNT, SET_ADDR, READ_DATA, WRITE_DATA, ALIVE, CORE_RST, CORE_NORM) into single-word bus-master transactions and drives reply bytes back to the UART transmitter. It also owns the debugger-controlled core reset. The UART RX/TX byte engines sit on either side of it; its bus port feeds the on-chip interconnect.

## Interface
- No parameters; address/data width fixed at 32 bits.
- `clk` in 1 — system clock.
- `n_rst` in 1 — asynchronous active-low reset.
- `rx_valid` in 1 — one-cycle strobe, new byte from UART RX.
- `rx_data` in 8 — received byte, valid with `rx_valid`.
- `tx_valid` out 1 — reply byte available; held until accepted.
- `tx_data` out 8 — reply byte; stable while `tx_valid`.
- `tx_ready` in 1 — UART TX accepts `tx_data` when `tx_valid && tx_ready`.
- `bus_addr` out 32 — word address of the current transaction.
- `bus_wdata` out 32 — write data.
- `bus_wen` out 1 — write request; held until completion.
- `bus_ren` out 1 — read request; held until completion.
- `bus_busy` in 1 — slave stall; a request completes in the first cycle it is asserted with `bus_busy=0`.
- `bus_rdata` in 32 — read data; sampled in the completion cycle.
- `core_rst_o` out 1 — holds the core in reset when 1.

## Operation
- Opcodes: 0x82 SET_COUNT, 0x83 SET_ADDR, 0x84 READ_DATA, 0x85 WRITE_DATA, 0x86 ALIVE, 0x87 CORE_RST, 0x88 CORE_NORM.
- Registers reset to: `count`=1, `addr`=0, `core_rst_o`=0.
- IDLE: an `rx_valid` byte that matches an opcode dispatches it. Any other byte is discarded; the FSM stays in IDLE.
- SET_COUNT: next byte → `count` (8 bits); back to IDLE.
- SET_ADDR: next 4 bytes, MSB first, → `addr`; back to IDLE.
- WRITE_DATA: loop `count` times:
  - GET_WDATA collects 4 bytes, MSB first.
  - BUS_WRITE drives `bus_wen` with `bus_addr=addr` until completion.
  - Then `addr += 4`.
- READ_DATA: loop `count` times:
  - BUS_READ drives `bus_ren` until completion and captures `bus_rdata`.
  - SEND_RDATA emits 4 bytes, MSB first.
  - Then `addr += 4`.
- `count`=0 means READ_DATA/WRITE_DATA return to IDLE with no bus activity and no reply bytes.
- ALIVE: emits 0x00 then 0xAE; back to IDLE.
- CORE_RST sets `core_rst_o`=1; CORE_NORM clears it. Both return to IDLE the next cycle with no reply.
- States: IDLE, GET_COUNT, GET_ADDR, GET_WDATA, BUS_WRITE, BUS_READ, SEND_RDATA, SEND_ALIVE. A 2-bit byte index is shared by the multi-byte states; a 9-bit word counter is loaded from `count`.
- `addr` increments modulo 2^32 (0xFFFFFFFC wraps to 0). The updated `addr` persists after the command.
- `count` is not modified by transfers. A word counter is loaded from it at command start.
- `rx_valid` in BUS_WRITE, BUS_READ, SEND_RDATA or SEND_ALIVE: the byte is dropped. The host must pace its bytes.
- `bus_wen` and `bus_ren` are never both high.
- `core_rst_o` is independent of bus activity: the bus stays usable while the core is held in reset.

## Timing
- Every output is registered. Reset values: `tx_valid`=0, `tx_data`=0, `bus_wen`=0, `bus_ren`=0, `bus_addr`=0, `bus_wdata`=0, `core_rst_o`=0.
- Byte accept: the state or index update is visible the cycle after `rx_valid`.
- After the 4th data byte of a write, `bus_wen` rises the next cycle.
- With `bus_busy`=0, a write completes in its first request cycle. `bus_wen` falls the cycle after completion, and `bus_addr` then shows `addr+4`.
- Read: `bus_ren` completes in the cycle `bus_busy`=0. `tx_valid` rises the next cycle with byte [31:24].
- Consecutive read bytes: the next byte is presented the cycle after a handshake (`tx_valid && tx_ready`). A byte takes at least 1 cycle.
- After the last read byte is accepted, the next word's `bus_ren` asserts the following cycle.
- `n_rst` assertion mid-command: immediate abort to IDLE with all registers at reset values. Partial bytes are lost and `core_rst_o` is cleared.

## Structure
- Package `debug_pkg` holds:
  - opcode localparams;
  - `ALIVE_RESP` = 16'h00AE;
  - the `dbg_state_t` enum.
- Single flat module; no sub-module is needed. Data assembly is a 32-bit shift-in register; reply output is a 32-bit shift-out register.

## Test plan
- Reset, then 0x86 → reply bytes 0x00, 0xAE. No bus activity.
- 0x83 00 00 80 00, 0x82 01, 0x85 DE AD BE EF → one `bus_wen` with addr 0x8000 and wdata 0xDEADBEEF. `addr` becomes 0x8004.
- SET_ADDR 0x8000, SET_COUNT 2, READ_DATA with slave returning 0x11223344 then 0x55667788 and `bus_busy` high for 3 cycles each → reads at 0x8000 and 0x8004; reply 11 22 33 44 55 66 77 88. `tx_ready` toggled randomly.
- SET_COUNT 0, then 0x85 and 0x84 → no bus request and no reply. A following 0x86 still answers 0x00 0xAE.
- 0x87 → `core_rst_o`=1; a write during it still completes on the bus. 0x88 → `core_rst_o`=0. Stray bytes 0x05 and 0xFF in IDLE are ignored.
- SET_ADDR 0xFFFFFFFC, count 2, write → addresses 0xFFFFFFFC then 0x00000000. `n_rst` pulsed during a subsequent GET_ADDR → outputs return to reset values.
